// File: rtl/instruction_memory_if.sv
// Fetch and programming bus between the CPU and the instruction memory.
// The master side is the CPU and program loader; the slave side is the memory.
interface instruction_memory_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       PC;
    logic              READ;
    logic [31:0]       INSTRUCTION;
    logic              BUSYWAIT;
    logic              PROG_WRITE;
    logic [ADDR_W-1:0] PROG_ADDR;
    logic [7:0]        PROG_DATA;

    modport master (
        output PC, READ, PROG_WRITE, PROG_ADDR, PROG_DATA,
        input  INSTRUCTION, BUSYWAIT
    );

    modport slave (
        input  PC, READ, PROG_WRITE, PROG_ADDR, PROG_DATA,
        output INSTRUCTION, BUSYWAIT
    );
endinterface

// File: rtl/instruction_memory.sv
// Byte-addressed little-endian instruction memory with a fixed-latency fetch FSM.
// Define IMEM_HIT_BUFFER_EN to add a one-entry last-fetch buffer that serves repeats with no stall.
module instruction_memory #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic                  CLK,
    input logic                  RESET,
    instruction_memory_if.slave  bus
);
    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [WA_W-1:0] addr_q, addr_d;
    logic [31:0]     instr_q, instr_d;
    logic [7:0]      mem_q [2**ADDR_W];

    logic            hit;
    logic [WA_W-1:0] pcWord;
    logic [31:0]     readWord;
    logic            unusedPcBits;

    // Upper PC bits wrap and the low two are forced aligned, so only the word index matters.
    assign pcWord       = bus.PC[ADDR_W-1:2];
    assign unusedPcBits = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

    assign readWord = {mem_q[{addr_q, 2'd3}],
                       mem_q[{addr_q, 2'd2}],
                       mem_q[{addr_q, 2'd1}],
                       mem_q[{addr_q, 2'd0}]};

`ifdef IMEM_HIT_BUFFER_EN
    logic [WA_W-1:0] tag_q;
    logic            valid_q;

    assign hit = valid_q && (pcWord == tag_q) && (state_q == IDLE);

    // Any programming write may alter the buffered word, so it drops the entry outright.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= 1'b0;
        end else if (bus.PROG_WRITE) begin
            valid_q <= 1'b0;
        end else if (state_q == BUSY && count_q == 4'd0) begin
            valid_q <= 1'b1;
            tag_q   <= addr_q;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (bus.PROG_WRITE) begin
            mem_q[bus.PROG_ADDR] <= bus.PROG_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            addr_q  <= '0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (bus.READ && !hit) begin
                    addr_d  = pcWord;
                    count_d = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    instr_d = readWord;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.INSTRUCTION = instr_q;
    assign bus.BUSYWAIT    = !RESET && ((state_q == IDLE && bus.READ && !hit) || state_q == BUSY);

endmodule

// File: tb/tb_instruction_memory.sv
// Directed testbench for instruction_memory: reset, miss latency, wrap, abort, write collision,
// hit buffer (IMEM_HIT_BUFFER_EN aware) and back-to-back fetches.
module tb_instruction_memory;
    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int MISS_STALL = 1 + LATENCY;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    instruction_memory_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_memory #(
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic progByte(input logic [ADDR_W-1:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.PROG_WRITE = 1'b1;
        bus.PROG_ADDR  = addr;
        bus.PROG_DATA  = data;
        @(negedge clk);
        bus.PROG_WRITE = 1'b0;
    endtask

    // Issues one READ and counts BUSYWAIT cycles until the word is presented.
    task automatic doFetch(input logic [31:0] pc, output int stalls, output logic [31:0] word);
        @(negedge clk);
        bus.PC   = pc;
        bus.READ = 1'b1;
        #1;
        stalls = 0;
        while (bus.BUSYWAIT === 1'b1 && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        word     = bus.INSTRUCTION;
        bus.READ = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus.READ = 1'b1;
        bus.PC   = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busywait: got %b expected 0", bus.BUSYWAIT);
        end
        @(negedge clk);
        reset    = 1'b0;
        bus.READ = 1'b0;
        #1;
        checks++;
        if (bus.INSTRUCTION !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_instruction: got %h expected 00000000", bus.INSTRUCTION);
        end
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_busywait: got %b expected 0", bus.BUSYWAIT);
        end
    endtask

    task automatic test_load();
        logic [7:0] image [12];
        image = '{8'h08, 8'h00, 8'h04, 8'h00,
                  8'h13, 8'h05, 8'h10, 8'h00,
                  8'h93, 8'h05, 8'h20, 8'h00};
        for (int i = 0; i < 12; i++) progByte(ADDR_W'(i), image[i]);
    endtask

    task automatic test_basic_fetch();
        int stalls;
        logic [31:0] word;
        doFetch(32'h0, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL basic_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        checks++;
        if (word !== 32'h00040008) begin
            failures++;
            $display("[TB] FAIL basic_word: got %h expected 00040008", word);
        end
    endtask

    task automatic test_wrap_align();
        int stalls;
        logic [31:0] word;
        doFetch(32'h0000_0402, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL wrap_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        checks++;
        if (word !== 32'h00040008) begin
            failures++;
            $display("[TB] FAIL wrap_word: got %h expected 00040008", word);
        end
    endtask

    task automatic test_reset_abort();
        int stalls;
        logic [31:0] word;
        @(negedge clk);
        bus.PC   = 32'h4;
        bus.READ = 1'b1;
        @(negedge clk);
        bus.READ = 1'b0;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_busy1: got %b expected 1", bus.BUSYWAIT);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_busy_in_reset: got %b expected 0", bus.BUSYWAIT);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.INSTRUCTION !== 32'h0) begin
            failures++;
            $display("[TB] FAIL abort_instruction: got %h expected 00000000", bus.INSTRUCTION);
        end
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle_busywait: got %b expected 0", bus.BUSYWAIT);
        end
        doFetch(32'h4, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL abort_refetch_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        checks++;
        if (word !== 32'h00100513) begin
            failures++;
            $display("[TB] FAIL abort_refetch_word: got %h expected 00100513", word);
        end
    endtask

    task automatic test_write_collision();
        int stalls;
        logic [31:0] word;
        @(negedge clk);
        bus.PC   = 32'h0;
        bus.READ = 1'b1;
        @(negedge clk);
        bus.READ = 1'b0;
        @(negedge clk);
        bus.PROG_WRITE = 1'b1;
        bus.PROG_ADDR  = ADDR_W'(3);
        bus.PROG_DATA  = 8'hFF;
        @(negedge clk);
        bus.PROG_WRITE = 1'b0;
        #1;
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            failures++;
            $display("[TB] FAIL collide_done_busywait: got %b expected 0", bus.BUSYWAIT);
        end
        checks++;
        if (bus.INSTRUCTION !== 32'h00040008) begin
            failures++;
            $display("[TB] FAIL collide_old_word: got %h expected 00040008", bus.INSTRUCTION);
        end
        doFetch(32'h0, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL collide_refetch_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        checks++;
        if (word !== 32'hFF040008) begin
            failures++;
            $display("[TB] FAIL collide_new_word: got %h expected ff040008", word);
        end
        progByte(ADDR_W'(3), 8'h00);
    endtask

    task automatic test_hit_buffer();
        int stalls;
        logic [31:0] word;
        int expRepeat;
`ifdef IMEM_HIT_BUFFER_EN
        expRepeat = 0;
`else
        expRepeat = MISS_STALL;
`endif
        doFetch(32'h4, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL hit_first_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        doFetch(32'h4, stalls, word);
        checks++;
        if (stalls !== expRepeat) begin
            failures++;
            $display("[TB] FAIL hit_repeat_stall: got %0d expected %0d", stalls, expRepeat);
        end
        checks++;
        if (word !== 32'h00100513) begin
            failures++;
            $display("[TB] FAIL hit_repeat_word: got %h expected 00100513", word);
        end
        progByte(ADDR_W'(10'h200), 8'hAA);
        doFetch(32'h4, stalls, word);
        checks++;
        if (stalls !== MISS_STALL) begin
            failures++;
            $display("[TB] FAIL hit_after_write_stall: got %0d expected %0d", stalls, MISS_STALL);
        end
        checks++;
        if (word !== 32'h00100513) begin
            failures++;
            $display("[TB] FAIL hit_after_write_word: got %h expected 00100513", word);
        end
    endtask

    // READ stays high; each DONE cycle (BUSYWAIT low) advances PC to the next word.
    task automatic test_back_to_back();
        logic [31:0] expWord [3];
        int doneCount;
        int lastDone;
        expWord   = '{32'h00040008, 32'h00100513, 32'h00200593};
        doneCount = 0;
        lastDone  = 0;
        @(negedge clk);
        bus.PC   = 32'h0;
        bus.READ = 1'b1;
        for (int c = 0; c < 40 && doneCount < 3; c++) begin
            #1;
            if (bus.BUSYWAIT === 1'b0) begin
                checks++;
                if (bus.INSTRUCTION !== expWord[doneCount]) begin
                    failures++;
                    $display("[TB] FAIL b2b_word%0d: got %h expected %h", doneCount, bus.INSTRUCTION, expWord[doneCount]);
                end
                if (doneCount > 0) begin
                    checks++;
                    if (c - lastDone !== LATENCY + 2) begin
                        failures++;
                        $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", doneCount, c - lastDone, LATENCY + 2);
                    end
                end
                lastDone = c;
                doneCount++;
                if (doneCount < 3) bus.PC = 32'(doneCount * 4);
                else bus.READ = 1'b0;
            end
            @(negedge clk);
        end
        bus.READ = 1'b0;
        checks++;
        if (doneCount !== 3) begin
            failures++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneCount);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.PC         = 32'h0;
        bus.READ       = 1'b0;
        bus.PROG_WRITE = 1'b0;
        bus.PROG_ADDR  = '0;
        bus.PROG_DATA  = 8'h0;

        test_reset();
        test_load();
        test_basic_fetch();
        test_wrap_align();
        test_reset_abort();
        test_write_collision();
        test_hit_buffer();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
